// File: rtl/linked_fifo_pkg.sv
// Shared types and elaboration helpers for the linked multi-queue FIFO.
package linked_fifo_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lf_state_e;

    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Bit offset of a queue's count field inside the packed occupancy bus.
    function automatic int occ_lsb(input int qi, input int cw);
        return qi * cw;
    endfunction

endpackage

// File: rtl/linked_fifo_ram.sv
// Single-write, single-read storage array; read port is either registered or asynchronous.
module linked_fifo_ram #(
    parameter int W        = 8,
    parameter int D        = 32,
    parameter int AW       = 5,
    parameter bit REG_READ = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_r [D];

    // Storage write port; contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [W-1:0] rd_r;
            // Registered read samples the array before a same-cycle write lands
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_r <= {W{1'b0}};
                end else if (re) begin
                    rd_r <= mem_r[raddr];
                end
            end
            assign rdata = rd_r;
        end else begin : g_async_read
            logic unused_s;
            assign unused_s = re ^ rst_n;
            assign rdata    = mem_r[raddr];
        end
    endgenerate

endmodule

// File: rtl/linked_multi_fifo.sv
// QUEUES logical FIFOs threaded through one shared DEPTH-entry pool with a common free list.
module linked_multi_fifo
    import linked_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int QUEUES    = 8,
    parameter int AF_THRESH = 2,
    parameter int AW        = clog2_f(DEPTH),
    parameter int QW        = clog2_f(QUEUES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [QW-1:0]            push_q,
    input  logic [WIDTH-1:0]         d,
    input  logic                     pop,
    input  logic [QW-1:0]            pop_q,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic                     ready,
    output logic [QUEUES-1:0]        empty,
    output logic [QUEUES*(AW+1)-1:0] occupancy,
    output logic [AW:0]              free_count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     err_overflow,
    output logic                     err_underflow
);
    localparam int CW = AW + 1;

    lf_state_e         state_r, state_s;
    logic [AW-1:0]     idx_r, idx_s;
    logic              ready_r, ready_s, init_done_s;
    logic [AW-1:0]     head_r [QUEUES];
    logic [AW-1:0]     tail_r [QUEUES];
    logic [CW-1:0]     occ_r  [QUEUES];
    logic [AW-1:0]     head_s [QUEUES];
    logic [AW-1:0]     tail_s [QUEUES];
    logic [CW-1:0]     occ_s  [QUEUES];
    logic [QUEUES-1:0] empty_r;
    logic [AW-1:0]     free_head_r, free_head_s;
    logic [CW-1:0]     free_cnt_r, free_cnt_s;
    logic              full_r, af_r, q_valid_r, err_ovf_r, err_udf_r;
    logic              push_q_ok_s, pop_q_ok_s, push_ok_s, pop_ok_s, push_to_empty_s;
    logic [AW-1:0]     pop_node_s, push_node_s;
    logic              link_we_s;
    logic [AW-1:0]     link_waddr_s, link_wdata_s, link_raddr_s, link_rdata_s;

    generate
        if ((1 << QW) == QUEUES) begin : g_qpow2
            assign push_q_ok_s = 1'b1;
            assign pop_q_ok_s  = 1'b1;
        end else begin : g_qrange
            assign push_q_ok_s = (int'(push_q) < QUEUES);
            assign pop_q_ok_s  = (int'(pop_q) < QUEUES);
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Init walk: chain every entry into the free list, then open for traffic
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        ready_s     = ready_r;
        init_done_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                idx_s = idx_r + AW'(1);
                if (idx_r == AW'(DEPTH - 1)) begin
                    state_s     = ST_RUN;
                    ready_s     = 1'b1;
                    init_done_s = 1'b1;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_INIT;
                ready_s = 1'b0;
            end
        endcase
    end

    // Op acceptance, list pointer updates and the single link-RAM write
    always_comb begin
        pop_ok_s        = ready_r & pop & pop_q_ok_s & ~empty_r[pop_q];
        push_ok_s       = ready_r & push & push_q_ok_s & (~full_r | pop_ok_s);
        pop_node_s      = head_r[pop_q];
        // A simultaneous pop donates its node to the push, bypassing the free list
        push_node_s     = pop_ok_s ? pop_node_s : free_head_r;
        push_to_empty_s = empty_r[push_q] |
                          (pop_ok_s & (pop_q == push_q) & (occ_r[push_q] == CW'(1)));
        link_raddr_s    = pop_ok_s ? pop_node_s : free_head_r;
        head_s          = head_r;
        tail_s          = tail_r;
        occ_s           = occ_r;
        free_head_s     = free_head_r;
        free_cnt_s      = free_cnt_r;
        link_we_s       = 1'b0;
        link_waddr_s    = {AW{1'b0}};
        link_wdata_s    = {AW{1'b0}};

        if (init_done_s) begin
            free_head_s = {AW{1'b0}};
            free_cnt_s  = CW'(DEPTH);
        end else if (pop_ok_s && !push_ok_s) begin
            free_head_s = pop_node_s;
            free_cnt_s  = free_cnt_r + CW'(1);
        end else if (push_ok_s && !pop_ok_s) begin
            free_head_s = link_rdata_s;
            free_cnt_s  = free_cnt_r - CW'(1);
        end else begin
            free_head_s = free_head_r;
            free_cnt_s  = free_cnt_r;
        end

        if (state_r == ST_INIT) begin
            link_we_s    = 1'b1;
            link_waddr_s = idx_r;
            link_wdata_s = idx_r + AW'(1);
        end else if (push_ok_s && !push_to_empty_s) begin
            link_we_s    = 1'b1;
            link_waddr_s = tail_r[push_q];
            link_wdata_s = push_node_s;
        end else if (pop_ok_s && !push_ok_s) begin
            link_we_s    = 1'b1;
            link_waddr_s = pop_node_s;
            link_wdata_s = free_head_r;
        end else begin
            link_we_s    = 1'b0;
        end

        if (pop_ok_s) begin
            head_s[pop_q] = link_rdata_s;
            occ_s[pop_q]  = occ_r[pop_q] - CW'(1);
        end else begin
            occ_s[pop_q]  = occ_r[pop_q];
        end

        if (push_ok_s) begin
            if (push_to_empty_s) begin
                head_s[push_q] = push_node_s;
            end else begin
                tail_s[push_q] = tail_r[push_q];
            end
            tail_s[push_q] = push_node_s;
            occ_s[push_q]  = occ_s[push_q] + CW'(1);
        end else begin
            tail_s[push_q] = tail_r[push_q];
        end
    end

    // Queue pointers, pool counters, status and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {AW{1'b0}};
            ready_r     <= 1'b0;
            free_head_r <= {AW{1'b0}};
            free_cnt_r  <= {CW{1'b0}};
            full_r      <= 1'b1;
            af_r        <= 1'b1;
            q_valid_r   <= 1'b0;
            err_ovf_r   <= 1'b0;
            err_udf_r   <= 1'b0;
            empty_r     <= {QUEUES{1'b1}};
            for (int i = 0; i < QUEUES; i++) begin
                head_r[i] <= {AW{1'b0}};
                tail_r[i] <= {AW{1'b0}};
                occ_r[i]  <= {CW{1'b0}};
            end
        end else begin
            idx_r       <= idx_s;
            ready_r     <= ready_s;
            free_head_r <= free_head_s;
            free_cnt_r  <= free_cnt_s;
            full_r      <= (free_cnt_s == {CW{1'b0}});
            af_r        <= (free_cnt_s < CW'(AF_THRESH));
            q_valid_r   <= pop_ok_s;
            err_ovf_r   <= err_ovf_r | (push & ~push_ok_s);
            err_udf_r   <= err_udf_r | (pop & ~pop_ok_s);
            for (int i = 0; i < QUEUES; i++) begin
                head_r[i]  <= head_s[i];
                tail_r[i]  <= tail_s[i];
                occ_r[i]   <= occ_s[i];
                empty_r[i] <= (occ_s[i] == {CW{1'b0}});
            end
        end
    end

    linked_fifo_ram #(.W(AW), .D(DEPTH), .AW(AW), .REG_READ(1'b0)) u_link_ram (
        .clk(clk), .rst_n(rst_n), .we(link_we_s), .waddr(link_waddr_s), .wdata(link_wdata_s),
        .re(1'b0), .raddr(link_raddr_s), .rdata(link_rdata_s)
    );

    linked_fifo_ram #(.W(WIDTH), .D(DEPTH), .AW(AW), .REG_READ(1'b1)) u_data_ram (
        .clk(clk), .rst_n(rst_n), .we(push_ok_s), .waddr(push_node_s), .wdata(d),
        .re(pop_ok_s), .raddr(pop_node_s), .rdata(q)
    );

    generate
        for (genvar g = 0; g < QUEUES; g++) begin : g_occ
            assign occupancy[occ_lsb(g, CW) +: CW] = occ_r[g];
        end
    endgenerate

    assign q_valid       = q_valid_r;
    assign ready         = ready_r;
    assign empty         = empty_r;
    assign free_count    = free_cnt_r;
    assign full          = full_r;
    assign almost_full   = af_r;
    assign err_overflow  = err_ovf_r;
    assign err_underflow = err_udf_r;

endmodule

// File: tb/tb_linked_multi_fifo.sv
// Directed and randomized checks of linked_multi_fifo against a queue-based reference model.
module tb_linked_multi_fifo;
    localparam int DEPTH  = 32;
    localparam int QUEUES = 8;
    localparam int CW     = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   push = 1'b0, pop = 1'b0;
    logic [2:0]             push_q = 3'd0, pop_q = 3'd0;
    logic [7:0]             d = 8'd0;
    logic [7:0]             q;
    logic                   q_valid, ready, full, almost_full, err_overflow, err_underflow;
    logic [QUEUES-1:0]      empty;
    logic [QUEUES*CW-1:0]   occupancy;
    logic [5:0]             free_count;

    linked_multi_fifo dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_q(push_q), .d(d), .pop(pop), .pop_q(pop_q),
        .q(q), .q_valid(q_valid), .ready(ready), .empty(empty), .occupancy(occupancy),
        .free_count(free_count), .full(full), .almost_full(almost_full),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq [QUEUES][$];
    bit         m_ready, m_qv, m_ovf, m_udf;
    logic [7:0] m_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_total();
        int t = 0;
        for (int i = 0; i < QUEUES; i++) t += mq[i].size();
        return t;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < QUEUES; i++) mq[i].delete();
        m_ready = 1'b0; m_qv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_q = 8'h00;
    endtask

    task automatic check_all(input string tag);
        logic [QUEUES*CW-1:0] eo;
        logic [QUEUES-1:0]    ee;
        int                   fc;
        for (int i = 0; i < QUEUES; i++) begin
            eo[i*CW +: CW] = CW'(mq[i].size());
            ee[i]          = (mq[i].size() == 0);
        end
        fc = m_ready ? DEPTH - m_total() : 0;
        chk({tag, ".ready"}, ready, m_ready);
        chk({tag, ".q_valid"}, q_valid, m_qv);
        if (m_qv) chk({tag, ".q"}, q, m_q);
        chk({tag, ".free_count"}, free_count, fc);
        chk({tag, ".empty"}, empty, ee);
        chk({tag, ".occupancy"}, occupancy, eo);
        chk({tag, ".full"}, full, fc == 0);
        chk({tag, ".almost_full"}, almost_full, fc < 2);
        chk({tag, ".err_overflow"}, err_overflow, m_ovf);
        chk({tag, ".err_underflow"}, err_underflow, m_udf);
    endtask

    task automatic do_op(input string tag, input bit p, input logic [2:0] pq, input logic [7:0] dd,
                         input bit o, input logic [2:0] oq);
        bit pop_acc, push_acc;
        push = p; push_q = pq; d = dd; pop = o; pop_q = oq;
        pop_acc  = m_ready && o && (mq[oq].size() > 0);
        push_acc = m_ready && p && ((m_total() < DEPTH) || pop_acc);
        @(posedge clk); #1;
        m_qv = pop_acc;
        if (pop_acc) m_q = mq[oq].pop_front();
        if (push_acc) mq[pq].push_back(dd);
        if (p && !push_acc) m_ovf = 1'b1;
        if (o && !pop_acc) m_udf = 1'b1;
        push = 1'b0; pop = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int cyc;
        int bias;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.q", q, 8'h00);

        rst_n = 1'b1;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk("init_cycles", cyc, 32);
        m_ready = 1'b1;
        check_all("init_done");

        do_op("push11", 1'b1, 3'd3, 8'h11, 1'b0, 3'd0);
        do_op("push22", 1'b1, 3'd3, 8'h22, 1'b0, 3'd0);
        do_op("push33", 1'b1, 3'd3, 8'h33, 1'b0, 3'd0);
        do_op("pop3a", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
        chk("pop3a.q_const", q, 8'h11);
        do_op("pop3b", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
        chk("pop3b.q_const", q, 8'h22);
        do_op("pop3c", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
        chk("pop3c.q_const", q, 8'h33);
        chk("pop3c.empty3", empty[3], 1'b1);

        for (int i = 0; i < 32; i++) begin
            do_op("fill", 1'b1, (i % 2 == 0) ? 3'd0 : 3'd5, 8'(8'h40 + i), 1'b0, 3'd0);
            if (i == 29) chk("fill30.almost_full", almost_full, 1'b0);
            if (i == 30) chk("fill31.almost_full", almost_full, 1'b1);
            if (i == 30) chk("fill31.full", full, 1'b0);
        end
        chk("fill.full", full, 1'b1);
        do_op("overflow", 1'b1, 3'd5, 8'hEE, 1'b0, 3'd0);
        chk("overflow.err", err_overflow, 1'b1);
        chk("overflow.occ5", occupancy[5*CW +: CW], 6'd16);

        do_op("full_pushpop", 1'b1, 3'd2, 8'h77, 1'b1, 3'd0);
        chk("full_pushpop.q_const", q, 8'h40);
        chk("full_pushpop.free", free_count, 6'd0);
        chk("full_pushpop.occ0", occupancy[0*CW +: CW], 6'd15);
        chk("full_pushpop.occ2", occupancy[2*CW +: CW], 6'd1);

        for (int qi = 0; qi < QUEUES; qi++) begin
            while (mq[qi].size() > 0) do_op("drain", 1'b0, 3'd0, 8'h00, 1'b1, 3'(qi));
        end

        do_op("q6_seed", 1'b1, 3'd6, 8'hA5, 1'b0, 3'd0);
        do_op("q6_swap", 1'b1, 3'd6, 8'h5A, 1'b1, 3'd6);
        chk("q6_swap.q_const", q, 8'hA5);
        chk("q6_swap.occ6", occupancy[6*CW +: CW], 6'd1);
        do_op("q6_pop", 1'b0, 3'd0, 8'h00, 1'b1, 3'd6);
        chk("q6_pop.q_const", q, 8'h5A);

        do_op("underflow", 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
        chk("underflow.err", err_underflow, 1'b1);
        chk("underflow.q_valid", q_valid, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            bias = ((n / 400) % 2 == 0) ? 70 : 30;
            do_op("rand", $urandom_range(99) < bias, 3'($urandom_range(7)), 8'($urandom),
                  $urandom_range(99) >= bias, 3'($urandom_range(7)));
        end

        for (int i = 0; i < 5; i++) do_op("pre_rst", 1'b1, 3'(i), 8'(i), 1'b0, 3'd0);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("mid_reset");
        chk("mid_reset.q", q, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op("init_push", 1'b1, 3'd4, 8'h99, 1'b0, 3'd0);
        cyc = 1;
        while (!ready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk("reinit_cycles", cyc, 32);
        m_ready = 1'b1;
        check_all("reinit_done");
        for (int n = 0; n < 300; n++) begin
            do_op("rand2", $urandom_range(99) < 60, 3'($urandom_range(7)), 8'($urandom),
                  $urandom_range(99) < 50, 3'($urandom_range(7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
